instruc_loader: RTL

- Upstream feeder of the fetch stage's instruction memory.
- Assembles program bytes arriving from the debug UART receiver into 32-bit words.
- Drives memory write address/data/strobe into the fetch stage until a halt word is written or memory is full.
- Reports busy/done/overflow to the debug unit, which holds the pipeline stepped off while loading.

---
 rtl/instruc_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/instruc_loader.sv
// -----------------------------------------------------------------------------
// instruc_loader
//
// Feeds the fetch stage's instruction memory from the debug UART receiver.
// Bytes arrive big-endian (first byte is the MSB). Every four bytes are
// assembled into one word, which is written with a one-cycle strobe. Loading
// stops when the halt word has been written (DONE) or when the memory fills
// without a halt word (ERROR).
//
// Optional feature, selected by defining the macro LOADER_CHECKSUM_EN:
//   A running XOR of every byte accepted since i_start, halt word included.
//   After the halt word is written, one more byte is expected. If it matches
//   the XOR, the loader goes to DONE with o_checksum_err = 0. Otherwise it
//   goes to DONE with o_checksum_err = 1. Without the macro there is no CHECK
//   state and o_checksum_err is tied to 0.
// -----------------------------------------------------------------------------
module instruc_loader #(
  parameter int                   BITS_SIZE  = 32,
  parameter int                   SIZE_TOTAL = 256,
  parameter int                   BYTE_SIZE  = 8,
  parameter logic [BITS_SIZE-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [BYTE_SIZE-1:0] i_rx_data,
  input  logic                 i_rx_done,
  output logic [BITS_SIZE-1:0] o_instruction_address,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_flag_write_intruc,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic                 o_checksum_err
);

  // Word geometry derived from the parameters.
  localparam int                   WORD_BYTES = BITS_SIZE / BYTE_SIZE;
  localparam int                   CNT_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0]     LAST_BYTE  = CNT_W'(WORD_BYTES - 1);
  localparam logic [BITS_SIZE-1:0] ADDR_STEP  = BITS_SIZE'(WORD_BYTES);
  localparam logic [BITS_SIZE-1:0] LAST_ADDR  = BITS_SIZE'(SIZE_TOTAL - WORD_BYTES);

  // State encoding, kept as plain constants so that legacy tooling can decode it.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHECK = 3'd5;
`endif

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     byte_cnt_q;
  logic [BITS_SIZE-1:0] shift_q;
  logic [BITS_SIZE-1:0] addr_q;
  logic [BITS_SIZE-1:0] instr_q;
  logic [BITS_SIZE-1:0] waddr_q;
  logic                 accept_byte;
  logic                 word_complete;
  logic                 advance_addr;

  // Next-state decision. i_start overrides everything, including a byte that
  // arrives in the same cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    if (i_start) begin
      state_d = ST_RECV;
    end else begin
      case (state_q)
        ST_RECV: begin
          if (i_rx_done && (byte_cnt_q == LAST_BYTE)) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          if (instr_q == HALT_INSTR) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else if (addr_q == LAST_ADDR) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_RECV;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (i_rx_done) state_d = ST_DONE;
        end
`endif
        default: state_d = state_q;
      endcase
    end
  end

  // A byte is taken while receiving. It is also taken during the write cycle
  // when loading continues, and then it becomes byte 1 of the next word.
  always_comb begin
    accept_byte   = !i_start && i_rx_done &&
                    ((state_q == ST_RECV) ||
                     ((state_q == ST_WRITE) && (state_d == ST_RECV)));
    word_complete = accept_byte && (byte_cnt_q == LAST_BYTE);
    advance_addr  = !i_start && (state_q == ST_WRITE) && (state_d == ST_RECV);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment, so every
      // flop samples values from before the edge, whatever the block order.
      state_q <= state_d;
    end
  end

  // Byte assembly, the address counter, and the registered write-port
  // outputs. The write-port outputs change only when a word completes, so they
  // hold their values outside the write cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      instr_q    <= '0;
      waddr_q    <= '0;
    end else if (i_start) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
    end else begin
      if (accept_byte) begin
        shift_q    <= {shift_q[BITS_SIZE-BYTE_SIZE-1:0], i_rx_data};
        byte_cnt_q <= word_complete ? '0 : byte_cnt_q + 1'b1;
      end
      if (word_complete) begin
        instr_q <= {shift_q[BITS_SIZE-BYTE_SIZE-1:0], i_rx_data};
        waddr_q <= addr_q;
      end
      if (advance_addr) begin
        addr_q <= addr_q + ADDR_STEP;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_SIZE-1:0] xor_q;
  logic                 chk_err_q;

  // Running XOR of the accepted bytes, and the comparison against the
  // trailing checksum byte.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (i_start) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (accept_byte) xor_q <= xor_q ^ i_rx_data;
      if ((state_q == ST_CHECK) && i_rx_done) chk_err_q <= (i_rx_data != xor_q);
    end
  end

  assign o_checksum_err = chk_err_q;
  assign o_busy         = (state_q == ST_RECV) || (state_q == ST_WRITE) ||
                          (state_q == ST_CHECK);
`else
  assign o_checksum_err = 1'b0;
  assign o_busy         = (state_q == ST_RECV) || (state_q == ST_WRITE);
`endif

  // Status and write strobe, decoded directly from the state.
  assign o_flag_write_intruc   = (state_q == ST_WRITE);
  assign o_done                = (state_q == ST_DONE);
  assign o_overflow            = (state_q == ST_ERROR);
  assign o_instruction         = instr_q;
  assign o_instruction_address = waddr_q;

endmodule
